mem_stage: RTL and testbench

//  - Memory-access stage directly downstream of the ALU. Takes the ALU result (y) as effective address or pass-through result.
//  - Performs byte/half/word loads and stores against a variable-latency data-memory port (req/gnt/rvalid).
//  - Big-endian lane alignment; loads are sign- or zero-extended.
//  - Hands one registered result per instruction to writeback over a valid/ready handshake.

---
 rtl/mem_defs.sv | 32 +++
 rtl/mem_stage_if.sv | 32 +++
 rtl/mem_stage_load_align.sv | 29 ++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_defs.sv
// Shared encodings for the memory stage: instruction kind, access size, FSM state,
// plus lane helpers for big-endian byte enables and store replication.
package mem_defs;
  typedef enum logic [1:0] {KIND_ALU = 2'd0, KIND_LOAD = 2'd1, KIND_STORE = 2'd2, KIND_RSVD = 2'd3} kind_t;
  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2, SIZE_RSVD = 2'd3} size_t;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_RESP = 2'd3} state_t;

  // Per-access info latched at accept and needed again when load data returns.
  typedef struct packed {
    size_t      size;
    logic [1:0] off;
    logic       sgn;
    logic       load;
  } acc_t;

  // be[3] covers bits 31:24, the lowest byte address.
  function automatic logic [3:0] lane_be(input size_t sz, input logic [1:0] off);
    case (sz)
      SIZE_B:  lane_be = 4'b1000 >> off;
      SIZE_H:  lane_be = off[1] ? 4'b0011 : 4'b1100;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_rep(input size_t sz, input logic [31:0] d);
    case (sz)
      SIZE_B:  store_rep = {4{d[7:0]}};
      SIZE_H:  store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// EX-in, data-memory and writeback signal bundle for mem_stage.
// master = the stage itself, slave = its environment (EX, memory, WB).
interface mem_stage_if #(parameter int AW = 32);
  logic          ex_valid, ex_ready;
  logic [1:0]    ex_kind, ex_size;
  logic          ex_signed;
  logic [31:0]   alu_y, ex_wdata;
  logic [4:0]    ex_rd;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt, mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          wb_valid, wb_ready, wb_we;
  logic [4:0]    wb_rd;
  logic [31:0]   wb_data;
  logic          trap;

  modport master (
    input  ex_valid, ex_kind, ex_size, ex_signed, alu_y, ex_wdata, ex_rd,
           mem_gnt, mem_rvalid, mem_rdata, wb_ready,
    output ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_we, wb_rd, wb_data, trap
  );
  modport slave (
    output ex_valid, ex_kind, ex_size, ex_signed, alu_y, ex_wdata, ex_rd,
           mem_gnt, mem_rvalid, mem_rdata, wb_ready,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           wb_valid, wb_we, wb_rd, wb_data, trap
  );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: picks the big-endian lane out of a load word and sign/zero-extends it.
module load_align
  import mem_defs::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] data
);
  logic [3:0][7:0]  lanes;
  logic [1:0][15:0] halves;
  logic [7:0]       b;
  logic [15:0]      h;

  assign lanes  = rdata;
  assign halves = rdata;
  // Lowest address sits in the top lane, so the lane index is the inverted offset.
  assign b = lanes[~addr];
  assign h = halves[~addr[1]];

  always_comb begin
    case (size_t'(size))
      SIZE_B:  data = {{24{sgn & b[7]}}, b};
      SIZE_H:  data = {{16{sgn & h[15]}}, h};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: byte/half/word load-store stage between ALU and writeback.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage
  import mem_defs::*;
#(
  parameter int AW        = 32,
  parameter int TO_CYCLES = 64
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.master bus
);
  localparam int TW = (TO_CYCLES > 0) ? $clog2(TO_CYCLES + 1) : 1;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit MIS_TRAP = 1'b1;
`else
  localparam bit MIS_TRAP = 1'b0;
`endif

  state_t        st;
  acc_t          acc;
  logic [TW-1:0] to_cnt;
  logic          to_hit, rdy, is_mem, mis;
  size_t         sz;
  kind_t         kd;
  logic [AW-1:0] a;
  logic [1:0]    off;
  logic [31:0]   ld_data;

  assign rdy          = (st == ST_IDLE) && !bus.wb_valid;
  assign bus.ex_ready = rdy;
  assign to_hit       = (TO_CYCLES > 0) && (to_cnt == TW'(TO_CYCLES - 1));

  // Decode size/offset; without the trap option, misaligned low bits are simply cleared.
  always_comb begin
    sz     = size_t'(bus.ex_size);
    kd     = kind_t'(bus.ex_kind);
    is_mem = (kd == KIND_LOAD) || (kd == KIND_STORE);
    a      = bus.alu_y[AW-1:0];
    mis    = 1'b0;
    off    = a[1:0];
    case (sz)
      SIZE_B:  ;
      SIZE_H:  begin mis = a[0];  off = {a[1], 1'b0}; end
      default: begin mis = |a[1:0]; off = 2'b00; end
    endcase
  end

  load_align u_align (
    .rdata (bus.mem_rdata),
    .addr  (acc.off),
    .size  (acc.size),
    .sgn   (acc.sgn),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= ST_IDLE;
      acc           <= '0;
      to_cnt        <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.wb_valid  <= 1'b0;
      bus.wb_we     <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.trap      <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: if (bus.ex_valid && rdy) begin
          to_cnt      <= '0;
          bus.wb_rd   <= bus.ex_rd;
          bus.wb_data <= bus.alu_y;
          acc         <= '{size: sz, off: off, sgn: bus.ex_signed, load: (kd == KIND_LOAD)};
          if (is_mem && !(mis && MIS_TRAP)) begin
            st            <= ST_REQ;
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= (kd == KIND_STORE);
            bus.mem_addr  <= {a[AW-1:2], 2'b00};
            bus.mem_be    <= lane_be(sz, off);
            bus.mem_wdata <= store_rep(sz, bus.ex_wdata);
          end else begin
            // ALU-only result, or a misaligned access trapped without touching memory.
            st           <= ST_RESP;
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= !is_mem;
            bus.trap     <= is_mem;
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            to_cnt      <= '0;
            if (acc.load) st <= ST_WAIT;
            else begin
              st           <= ST_RESP;
              bus.wb_valid <= 1'b1;
              bus.wb_we    <= 1'b0;
              bus.trap     <= 1'b0;
            end
          end else if (to_hit) begin
            bus.mem_req  <= 1'b0;
            st           <= ST_RESP;
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= 1'b0;
            bus.trap     <= 1'b1;
          end else to_cnt <= to_cnt + 1'b1;
        end
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            st           <= ST_RESP;
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= 1'b1;
            bus.wb_data  <= ld_data;
            bus.trap     <= 1'b0;
          end else if (to_hit) begin
            st           <= ST_RESP;
            bus.wb_valid <= 1'b1;
            bus.wb_we    <= 1'b0;
            bus.trap     <= 1'b1;
          end else to_cnt <= to_cnt + 1'b1;
        end
        ST_RESP: if (bus.wb_ready) begin
          st           <= ST_IDLE;
          bus.wb_valid <= 1'b0;
          bus.wb_we    <= 1'b0;
          bus.trap     <= 1'b0;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed accesses push expected WB results,
// a negedge monitor pops and compares on every WB handshake.
module tb_mem_stage;
  import mem_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if #(.AW(32)) bus();
  mem_stage #(.AW(32), .TO_CYCLES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        trap;
    logic        chk_data;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && bus.wb_valid && bus.wb_ready) begin
      if (q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
        chk("wb_trap", {31'd0, bus.trap}, {31'd0, e.trap});
        if (e.chk_data) chk("wb_data", bus.wb_data, e.data);
      end
    end
  end

  task automatic expect_wb(input logic we, input logic [4:0] rd, input logic [31:0] d,
                           input logic tr, input logic cd);
    exp_t x;
    x = '{we: we, rd: rd, data: d, trap: tr, chk_data: cd};
    q.push_back(x);
  endtask

  task automatic issue(input logic [1:0] kind, input logic [1:0] size, input logic sgn,
                       input logic [31:0] y, input logic [31:0] wd, input logic [4:0] rd);
    int n = 0;
    while (!bus.ex_ready && n < 200) begin tick(); n++; end
    chk("ex_ready_wait", {31'd0, bus.ex_ready}, 32'd1);
    bus.ex_kind = kind; bus.ex_size = size; bus.ex_signed = sgn;
    bus.alu_y = y; bus.ex_wdata = wd; bus.ex_rd = rd; bus.ex_valid = 1'b1;
    tick();
    bus.ex_valid = 1'b0;
  endtask

  task automatic serve(input int gd, input int rdl, input logic [31:0] rdata,
                       input logic [31:0] eaddr, input logic [3:0] ebe, input logic ewe,
                       input logic [31:0] ewd);
    int n = 0;
    while (!bus.mem_req && n < 20) begin tick(); n++; end
    chk("mem_req_seen", {31'd0, bus.mem_req}, 32'd1);
    chk("mem_addr", bus.mem_addr, eaddr);
    chk("mem_be", {28'd0, bus.mem_be}, {28'd0, ebe});
    chk("mem_we", {31'd0, bus.mem_we}, {31'd0, ewe});
    if (ewe) chk("mem_wdata", bus.mem_wdata, ewd);
    for (int i = 0; i < gd; i++) begin
      tick();
      chk("mem_req_hold", {31'd0, bus.mem_req}, 32'd1);
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    chk("mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    if (!ewe) begin
      repeat (rdl) tick();
      bus.mem_rdata = rdata; bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin tick(); n++; end
    chk("drain", q.size(), 0);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    bus.ex_valid = 0; bus.ex_kind = 0; bus.ex_size = 0; bus.ex_signed = 0;
    bus.alu_y = 0; bus.ex_wdata = 0; bus.ex_rd = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0; bus.wb_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_wb_we", {31'd0, bus.wb_we}, 32'd0);
    chk("rst_trap", {31'd0, bus.trap}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wb_rd", {27'd0, bus.wb_rd}, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    rst = 1'b0;
    tick();

    // ALU-only: result visible right after the accepting edge
    expect_wb(1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b1);
    issue(KIND_ALU, SIZE_W, 1'b0, 32'h1234_5678, 32'h0, 5'd5);
    chk("alu_latency", {31'd0, bus.wb_valid}, 32'd1);
    drain();

    // LOAD byte signed @0x101, gnt after 2 cycles, rvalid 3 later
    expect_wb(1'b1, 5'd7, 32'hFFFF_FFF2, 1'b0, 1'b1);
    issue(KIND_LOAD, SIZE_B, 1'b1, 32'h0000_0101, 32'h0, 5'd7);
    serve(2, 3, 32'h11F2_3344, 32'h0000_0100, 4'b0100, 1'b0, 32'h0);
    drain();

    // STORE half @0x202
    expect_wb(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    issue(KIND_STORE, SIZE_H, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 5'd3);
    serve(1, 0, 32'h0, 32'h0000_0200, 4'b0011, 1'b1, 32'hABCD_ABCD);
    drain();

    // Byte zero-extended @0x1003, lowest lane
    expect_wb(1'b1, 5'd8, 32'h0000_009A, 1'b0, 1'b1);
    issue(KIND_LOAD, SIZE_B, 1'b0, 32'h0000_1003, 32'h0, 5'd8);
    serve(0, 0, 32'h1122_339A, 32'h0000_1000, 4'b0001, 1'b0, 32'h0);
    drain();

    // Half unsigned @0x2 and signed @0x8
    expect_wb(1'b1, 5'd9, 32'h0000_8765, 1'b0, 1'b1);
    issue(KIND_LOAD, SIZE_H, 1'b0, 32'h0000_0002, 32'h0, 5'd9);
    serve(0, 1, 32'h1234_8765, 32'h0000_0000, 4'b0011, 1'b0, 32'h0);
    drain();
    expect_wb(1'b1, 5'd10, 32'hFFFF_8765, 1'b0, 1'b1);
    issue(KIND_LOAD, SIZE_H, 1'b1, 32'h0000_0008, 32'h0, 5'd10);
    serve(1, 1, 32'h8765_1234, 32'h0000_0008, 4'b1100, 1'b0, 32'h0);
    drain();

    // STORE word, and reserved kind behaves as ALU-only
    expect_wb(1'b0, 5'd11, 32'h0, 1'b0, 1'b0);
    issue(KIND_STORE, SIZE_W, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 5'd11);
    serve(0, 0, 32'h0, 32'h0000_0020, 4'b1111, 1'b1, 32'hDEAD_BEEF);
    drain();
    expect_wb(1'b1, 5'd31, 32'h0000_A5A5, 1'b0, 1'b1);
    issue(KIND_RSVD, SIZE_W, 1'b0, 32'h0000_A5A5, 32'h0, 5'd31);
    drain();

    // LOAD word @0x3: trap or force-align depending on build
`ifdef MEM_MISALIGN_TRAP_EN
    expect_wb(1'b0, 5'd12, 32'h0000_0003, 1'b1, 1'b1);
    issue(KIND_LOAD, SIZE_W, 1'b0, 32'h0000_0003, 32'h0, 5'd12);
    chk("mis_no_req", {31'd0, bus.mem_req}, 32'd0);
    chk("mis_trap_next", {31'd0, bus.trap}, 32'd1);
`else
    expect_wb(1'b1, 5'd12, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(KIND_LOAD, SIZE_W, 1'b0, 32'h0000_0003, 32'h0, 5'd12);
    serve(0, 0, 32'hCAFE_F00D, 32'h0000_0000, 4'b1111, 1'b0, 32'h0);
`endif
    drain();

    // gnt withheld: mem_req held exactly 64 cycles, then trap
    expect_wb(1'b0, 5'd13, 32'h0, 1'b1, 1'b0);
    issue(KIND_STORE, SIZE_B, 1'b0, 32'h0000_0010, 32'h0000_005A, 5'd13);
    chk("to_mem_be", {28'd0, bus.mem_be}, 32'h8);
    chk("to_mem_wdata", bus.mem_wdata, 32'h5A5A_5A5A);
    n = 0;
    while (bus.mem_req && n < 200) begin n++; tick(); end
    chk("to_req_cycles", n, 64);
    chk("to_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("to_trap", {31'd0, bus.trap}, 32'd1);
    drain();

    // wb_ready low for 5 cycles: outputs hold, no new accept
    bus.wb_ready = 1'b0;
    expect_wb(1'b1, 5'd14, 32'h0BAD_F00D, 1'b0, 1'b1);
    issue(KIND_ALU, SIZE_W, 1'b0, 32'h0BAD_F00D, 32'h0, 5'd14);
    bus.alu_y = 32'h1111_1111;
    for (int i = 0; i < 5; i++) begin
      chk("stall_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("stall_wb_data", bus.wb_data, 32'h0BAD_F00D);
      chk("stall_wb_rd", {27'd0, bus.wb_rd}, 32'd14);
      chk("stall_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
      tick();
    end
    bus.wb_ready = 1'b1;
    drain();

    // Reset while waiting for rvalid: late rvalid must be ignored
    issue(KIND_LOAD, SIZE_W, 1'b0, 32'h0000_0040, 32'h0, 5'd15);
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mid_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    bus.mem_rdata = 32'h7777_7777; bus.mem_rvalid = 1'b1;
    tick();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_wb", {31'd0, bus.wb_valid}, 32'd0);
      tick();
    end

    // Recovery after mid-transaction reset
    expect_wb(1'b1, 5'd1, 32'h0000_0042, 1'b0, 1'b1);
    issue(KIND_ALU, SIZE_W, 1'b0, 32'h0000_0042, 32'h0, 5'd1);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
